// File: rtl/adder_share_ctrl.sv
// ---------------------------------------------------------------------------
// adder_share_ctrl
//
// Time-shares one external combinational adder among NUM_REQ requesters.
// A round-robin arbiter picks one requester, its operands are registered onto
// the adder, the (WIDTH+1)-bit result is captured one cycle later, and it is
// returned on a single response channel tagged with the requester index.
//
// Handshake rules (all channels):
//   A transfer happens on a rising edge where valid & ready are both high.
//   A producer holds valid and its payload stable until that transfer.
//   Ready may be computed from valid but never from the payload.
//   req_ready is one-hot-or-zero; rsp_* are held stable while rsp_ready=0.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   req_valid/ready per-requester request handshake (NUM_REQ bits)
//   req_a/req_b     packed operands, requester i at [i*WIDTH +: WIDTH]
//   adder_a/adder_b registered operands driven to the shared adder
//   adder_sum       adder result, bit WIDTH is the carry-out
//   rsp_valid/ready response handshake
//   rsp_sum/carry   captured result
//   rsp_id          requester that owns the response
//   busy            high whenever a transaction is in EXEC or RESP
//   done_count      completed responses, wraps 0xFFFF -> 0
//   state_dbg       current controller state (IDLE=0, EXEC=1, RESP=2)
// ---------------------------------------------------------------------------
module adder_share_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int ID_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         adder_a,
  output logic [WIDTH-1:0]         adder_b,
  input  logic [WIDTH:0]           adder_sum,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic [ID_WIDTH-1:0]      rsp_id,
  output logic                     busy,
  output logic [15:0]              done_count,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     adder_a_q, adder_a_d;
  logic [WIDTH-1:0]     adder_b_q, adder_b_d;
  logic [ID_WIDTH-1:0]  id_reg_q, id_reg_d;
  logic [ID_WIDTH-1:0]  last_grant_q, last_grant_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]     rsp_sum_q, rsp_sum_d;
  logic                 rsp_carry_q, rsp_carry_d;
  logic [ID_WIDTH-1:0]  rsp_id_q, rsp_id_d;
  logic [15:0]          done_count_q, done_count_d;

  logic                 arb_en;
  logic                 grant_found;
  logic [ID_WIDTH-1:0]  grant_idx;
  logic                 accept;
  logic [WIDTH-1:0]     sel_a;
  logic [WIDTH-1:0]     sel_b;

  // Arbitration runs in IDLE, and in RESP only once the current response is
  // being consumed, so a new accept overlaps the response drain.
  assign arb_en = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);

  // Round-robin search starting just after last_grant. Walking the offsets
  // from farthest to nearest lets the nearest valid requester win.
  always_comb begin
    int                  cand;
    logic [ID_WIDTH-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand     = (int'(last_grant_q) + k) % NUM_REQ;
      cand_idx = ID_WIDTH'(cand);
      if (req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (arb_en && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);
  assign sel_a  = req_a[grant_idx*WIDTH +: WIDTH];
  assign sel_b  = req_b[grant_idx*WIDTH +: WIDTH];

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    adder_a_d    = adder_a_q;
    adder_b_d    = adder_b_q;
    id_reg_d     = id_reg_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_id_d     = rsp_id_q;
    done_count_d = done_count_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Operands have been on the adder for a full cycle; capture result.
        rsp_sum_d   = adder_sum[WIDTH-1:0];
        rsp_carry_d = adder_sum[WIDTH];
        rsp_id_d    = id_reg_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          done_count_d = done_count_q + 16'd1;
          rsp_valid_d  = 1'b0;
          state_d      = accept ? ST_EXEC : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      adder_a_d    = sel_a;
      adder_b_d    = sel_b;
      id_reg_d     = grant_idx;
      last_grant_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      adder_a_q    <= '0;
      adder_b_q    <= '0;
      id_reg_q     <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      rsp_valid_q  <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_id_q     <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      adder_a_q    <= adder_a_d;
      adder_b_q    <= adder_b_d;
      id_reg_q     <= id_reg_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_id_q     <= rsp_id_d;
      done_count_q <= done_count_d;
    end
  end

  assign adder_a    = adder_a_q;
  assign adder_b    = adder_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_sum    = rsp_sum_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_id     = rsp_id_q;
  assign done_count = done_count_q;
  assign busy       = (state_q != ST_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for adder_share_ctrl (NUM_REQ=4, WIDTH=8, ID_WIDTH=2).
// Inputs are driven just after the falling edge; outputs are sampled 1ns
// after the drive, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_adder_share_ctrl;

  localparam int NUM_REQ  = 4;
  localparam int WIDTH    = 8;
  localparam int ID_WIDTH = 2;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         adder_a;
  logic [WIDTH-1:0]         adder_b;
  logic [WIDTH:0]           adder_sum;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_carry;
  logic [ID_WIDTH-1:0]      rsp_id;
  logic                     busy;
  logic [15:0]              done_count;
  logic [1:0]               state_dbg;

  int total = 0;
  int bad   = 0;

  // The shared adder that lives outside the controller.
  assign adder_sum = {1'b0, adder_a} + {1'b0, adder_b};

  adder_share_ctrl #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .ID_WIDTH(ID_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_sum (adder_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .done_count(done_count),
    .state_dbg (state_dbg)
  );

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // One full transaction from IDLE with rsp_ready held high. Returns the
  // captured response and whether both the accept and the response arrived
  // within their cycle budgets.
  task automatic run_txn(input int idx, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] s, output logic c,
                         output logic [1:0] id, output bit ok);
    int n;
    bit acc;
    step();
    rsp_ready = 1'b1;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
    #1;
    n = 0;
    while (!req_ready[idx] && n < 8) begin
      step();
      n++;
    end
    acc = req_ready[idx];
    step();
    req_valid = '0;
    #1;
    n = 0;
    while (!rsp_valid && n < 8) begin
      step();
      n++;
    end
    ok = acc && rsp_valid;
    s  = rsp_sum;
    c  = rsp_carry;
    id = rsp_id;
    step();
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    reset_pulse();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_sum !== 8'h00) begin bad++; $display("FAIL reset_rsp_sum got=%h exp=00", rsp_sum); end
    total++; if (rsp_carry !== 1'b0) begin bad++; $display("FAIL reset_rsp_carry got=%b exp=0", rsp_carry); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    total++; if (adder_a !== 8'h00 || adder_b !== 8'h00) begin bad++; $display("FAIL reset_adder_ops got=%h/%h exp=00/00", adder_a, adder_b); end
    total++; if (done_count !== 16'h0000) begin bad++; $display("FAIL reset_done_count got=%h exp=0000", done_count); end
    total++; if (busy !== 1'b0 || state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got busy=%b st=%0d exp busy=0 st=0", busy, state_dbg); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
  endtask

  task automatic test_single();
    step();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_a[2*WIDTH +: WIDTH] = 8'h12;
    req_b[2*WIDTH +: WIDTH] = 8'h34;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    step();
    req_valid = '0;
    #1;
    total++; if (state_dbg !== 2'd1 || busy !== 1'b1) begin bad++; $display("FAIL single_exec got st=%0d busy=%b exp st=1 busy=1", state_dbg, busy); end
    total++; if (adder_a !== 8'h12 || adder_b !== 8'h34) begin bad++; $display("FAIL single_operands got=%h/%h exp=12/34", adder_a, adder_b); end
    step();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    total++; if (rsp_sum !== 8'h46 || rsp_carry !== 1'b0 || rsp_id !== 2'd2) begin bad++; $display("FAIL single_rsp got sum=%h c=%b id=%0d exp sum=46 c=0 id=2", rsp_sum, rsp_carry, rsp_id); end
    total++; if (done_count !== 16'd0) begin bad++; $display("FAIL single_count_before got=%0d exp=0", done_count); end
    step();
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_drain got v=%b busy=%b exp v=0 busy=0", rsp_valid, busy); end
    total++; if (done_count !== 16'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", done_count); end
  endtask

  task automatic test_overflow();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] es [3];
    logic       ec [3];
    logic [7:0] s;
    logic       c;
    logic [1:0] id;
    bit         ok;
    va = '{8'hFF, 8'h80, 8'h7F};
    vb = '{8'h01, 8'h80, 8'h01};
    es = '{8'h00, 8'h00, 8'h80};
    ec = '{1'b1,  1'b1,  1'b0};
    for (int i = 0; i < 3; i++) begin
      run_txn(0, va[i], vb[i], s, c, id, ok);
      total++; if (!ok) begin bad++; $display("FAIL overflow_timeout vec=%0d got=no_response exp=response", i); end
      total++; if (s !== es[i] || c !== ec[i] || id !== 2'd0) begin bad++; $display("FAIL overflow vec=%0d got sum=%h c=%b id=%0d exp sum=%h c=%b id=0", i, s, c, id, es[i], ec[i]); end
    end
    total++; if (done_count !== 16'd4) begin bad++; $display("FAIL overflow_count got=%0d exp=4", done_count); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_sum [4];
    logic [3:0] exp_rdy;
    exp_sum = '{8'h13, 8'h24, 8'h35, 8'h46};
    reset_pulse();
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = 8'(8'h10 * (i + 1));
      req_b[i*WIDTH +: WIDTH] = 8'(i + 3);
    end
    step();
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = '0;
      exp_rdy[k % 4] = 1'b1;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
      step();
      total++; if (req_ready !== 4'b0000 || state_dbg !== 2'd1) begin bad++; $display("FAIL rr_exec k=%0d got rdy=%b st=%0d exp rdy=0000 st=1", k, req_ready, state_dbg); end
      step();
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_sum !== exp_sum[k % 4]) begin bad++; $display("FAIL rr_rsp k=%0d got v=%b id=%0d sum=%h exp v=1 id=%0d sum=%h", k, rsp_valid, rsp_id, rsp_sum, k % 4, exp_sum[k % 4]); end
    end
    req_valid = '0;
    #1;
    step();
    // Lone grant to requester 3, then all valid: requester 0 is next.
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL rr_lone3 got=%b exp=1000", req_ready); end
    step();
    req_valid = '0;
    step();
    total++; if (rsp_id !== 2'd3 || rsp_sum !== 8'h46) begin bad++; $display("FAIL rr_lone3_rsp got id=%0d sum=%h exp id=3 sum=46", rsp_id, rsp_sum); end
    step();
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rr_after3 got=%b exp=0001", req_ready); end
    req_valid = '0;
    #1;
    total++; if (done_count !== 16'd7) begin bad++; $display("FAIL rr_count got=%0d exp=7", done_count); end
  endtask

  task automatic test_backpressure();
    step();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_a[1*WIDTH +: WIDTH] = 8'h05;
    req_b[1*WIDTH +: WIDTH] = 8'h07;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_first_grant got=%b exp=0010", req_ready); end
    step();
    // Requester 1 immediately offers a second operand pair.
    req_a[1*WIDTH +: WIDTH] = 8'h21;
    req_b[1*WIDTH +: WIDTH] = 8'h22;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_exec_ready got=%b exp=0000", req_ready); end
    step();
    for (int i = 0; i < 5; i++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_sum !== 8'h0C || rsp_carry !== 1'b0 || rsp_id !== 2'd1) begin bad++; $display("FAIL bp_hold cyc=%0d got v=%b sum=%h c=%b id=%0d exp v=1 sum=0c c=0 id=1", i, rsp_valid, rsp_sum, rsp_carry, rsp_id); end
      total++; if (req_ready !== 4'b0000 || done_count !== 16'd7) begin bad++; $display("FAIL bp_stall cyc=%0d got rdy=%b cnt=%0d exp rdy=0000 cnt=7", i, req_ready, done_count); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", req_ready); end
    step();
    req_valid = '0;
    #1;
    total++; if (state_dbg !== 2'd1 || rsp_valid !== 1'b0 || done_count !== 16'd8) begin bad++; $display("FAIL bp_next_exec got st=%0d v=%b cnt=%0d exp st=1 v=0 cnt=8", state_dbg, rsp_valid, done_count); end
    total++; if (adder_a !== 8'h21 || adder_b !== 8'h22) begin bad++; $display("FAIL bp_second_ops got=%h/%h exp=21/22", adder_a, adder_b); end
    step();
    total++; if (rsp_sum !== 8'h43 || rsp_id !== 2'd1) begin bad++; $display("FAIL bp_second_rsp got sum=%h id=%0d exp sum=43 id=1", rsp_sum, rsp_id); end
    step();
    total++; if (done_count !== 16'd9 || busy !== 1'b0) begin bad++; $display("FAIL bp_end got cnt=%0d busy=%b exp cnt=9 busy=0", done_count, busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] s;
    logic       c;
    logic [1:0] id;
    bit         ok;
    step();
    force dut.done_count_q = 16'hFFFF;
    #1;
    release dut.done_count_q;
    #1;
    total++; if (done_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffff", done_count); end
    run_txn(3, 8'h01, 8'h02, s, c, id, ok);
    total++; if (!ok || s !== 8'h03 || id !== 2'd3) begin bad++; $display("FAIL wrap_txn got ok=%b sum=%h id=%0d exp ok=1 sum=03 id=3", ok, s, id); end
    total++; if (done_count !== 16'h0000) begin bad++; $display("FAIL wrap_count got=%h exp=0000", done_count); end
  endtask

  task automatic test_reset_mid();
    step();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rstmid_grant got=%b exp=0100", req_ready); end
    step();
    req_valid = '0;
    #1;
    total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL rstmid_in_exec got st=%0d exp=1", state_dbg); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_count !== 16'd0) begin bad++; $display("FAIL rstmid_after got v=%b busy=%b cnt=%0d exp v=0 busy=0 cnt=0", rsp_valid, busy, done_count); end
    step();
    total++; if (rsp_valid !== 1'b0 || rsp_sum !== 8'h00) begin bad++; $display("FAIL rstmid_no_rsp got v=%b sum=%h exp v=0 sum=00", rsp_valid, rsp_sum); end
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rstmid_priority got=%b exp=0001", req_ready); end
    req_valid = '0;
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
